prm_edge_chk_engine: RTL
========================

Name: prm_edge_chk_engine

Overview:
- Programmable, sequential successor to the fixed sum-of-products obstacle/edge checkers used in the PRM collision truth tables.
- Holds up to MAX_CUBES product terms in a loadable table. Each cube is a care mask plus a value.
- Evaluates an IN_W-bit query vector against LANES cubes per cycle and stops early on the first hit.
- Returns edge_mask with the query ID and the index of the hit cube. It sits between the roadmap edge generator and the edge-validity bitmap writer, replacing one hard-coded chk module per table.

Parameters:
- IN_W, 15, query vector width (literal count; bit 0 = A).
- MAX_CUBES, 256, cube table depth; power of two.
- LANES, 4, cubes compared per cycle; divides MAX_CUBES.
- ID_W, 16, query tag width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- cfg_we  in  1  write one cube entry.
- cfg_addr  in  log2(MAX_CUBES)  entry index.
- cfg_care  in  IN_W  care mask; 1 = literal present.
- cfg_val  in  IN_W  required literal polarity.
- cfg_num_we  in  1  write active cube count.
- cfg_num  in  log2(MAX_CUBES)+1  active cube count, 0..MAX_CUBES.
- cfg_ready  out  1  config accepted this cycle.
- q_valid  in  1  query valid.
- q_ready  out  1  engine can accept a query.
- q_vec  in  IN_W  literal vector.
- q_id  in  ID_W  query tag.
- r_valid  out  1  result valid.
- r_ready  in  1  downstream accepts result.
- r_mask  out  1  edge_mask: 1 = some active cube matched.
- r_id  out  ID_W  tag of the answered query.
- r_hit_idx  out  log2(MAX_CUBES)  lowest matching cube index; 0 when r_mask=0.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Cube match rule: ((q_vec ^ val) & care) == 0. A cube with care=0 matches every vector.
- FSM states are IDLE, EVAL and RESP.
- IDLE:
  - q_ready=1.
  - On q_valid, latch q_vec and q_id and clear the base index to 0.
  - If num_cubes=0, go to RESP with r_mask=0. Otherwise go to EVAL.
- EVAL, one cycle per group:
  - Compare entries base..base+LANES-1. Lanes with index >= num_cubes are masked off.
  - On any hit: r_mask=1, r_hit_idx = lowest hitting index, go to RESP.
  - With no hit and base+LANES >= num_cubes: r_mask=0, go to RESP.
  - Otherwise base += LANES.
- RESP:
  - r_valid=1. Outputs are held stable until r_ready.
  - On r_valid&r_ready, go to IDLE.
  - No back-to-back bypass: next-query acceptance is the cycle after the handshake.
- Latency from query accept to r_valid:
  - 1 cycle when num_cubes=0.
  - Otherwise k+1 cycles, where k = number of groups evaluated. Worst case k = ceil(num_cubes/LANES).
- Cube table read:
  - The table is LANES banks, cube i in bank i mod LANES.
  - Read is combinational from registered base; no read latency inside EVAL.
- Configuration:
  - cfg_ready = !busy.
  - cfg_we or cfg_num_we while busy is ignored (dropped). The driver must check cfg_ready.
  - If cfg_we and cfg_num_we fall in the same cycle, both take effect.
  - A cfg_num above MAX_CUBES saturates to MAX_CUBES.
- Reset:
  - num_cubes=0. FSM enters IDLE.
  - r_valid=0, r_mask=0, r_id=0, r_hit_idx=0, busy=0.
  - q_ready=1 and cfg_ready=1 from the first cycle after reset.
  - The cube table is not reset.
  - A reset mid-EVAL or mid-RESP abandons the query with no result.
- q_ready=0 in EVAL and RESP. A q_valid held there is not consumed.

Decomposition:
- Shared package prm_chk_pkg holds:
  - cube_t typedef {care, val} of IN_W bits.
  - constants CUBE_IDX_W = log2(MAX_CUBES) and CNT_W = CUBE_IDX_W+1.
  - FSM state enum.
- Sub-module prm_cube_lane: combinational single-cube matcher (vec, cube, enable -> hit), instantiated LANES times.
- The engine holds the FSM, the banked table and the lowest-index priority encoder.

Test Plan:
- Empty table: num_cubes=0, query vec=0x7FFF id=0x0011 -> r_valid one cycle after accept, r_mask=0, r_id=0x0011, r_hit_idx=0.
- Single cube: cube0 care=0x7FFF val=0x5A5A, num=1.
  - Query 0x5A5A -> r_mask=1, hit_idx=0, latency 2.
  - Query 0x5A5B -> r_mask=0.
- Early exit across groups: num=10, only cube9 care=0x0003 val=0x0002 matches query 0x0006 -> hit_idx=9, latency 4 (3 groups + 1). Cubes 5 and 9 both matching -> hit_idx=5, latency 3.
- Count masking: cube5 care=0 (matches all) with num=5 -> r_mask=0. Raise num to 6 -> r_mask=1, hit_idx=5.
- Backpressure and config lockout:
  - Hold r_ready=0 for 5 cycles -> r_valid, r_mask, r_id stable and q_ready=0.
  - cfg_we issued during the query -> cfg_ready=0 and the table is unchanged, checked by re-query.
- Reset mid-EVAL: assert rst during EVAL of a 256-cube query -> next cycle r_valid=0, busy=0, q_ready=1, num_cubes=0. A new query returns r_mask=0.

Source files
------------

// File: rtl/prm_chk_pkg.sv
// Shared types and constants for the programmable PRM edge checker.
// Cube = care mask + required polarity; table sizing derives from MAX_CUBES/LANES.
package prm_chk_pkg;
  localparam int IN_W       = 15;
  localparam int MAX_CUBES  = 256;
  localparam int LANES      = 4;
  localparam int ID_W       = 16;
  localparam int CUBE_IDX_W = $clog2(MAX_CUBES);
  localparam int CNT_W      = CUBE_IDX_W + 1;
  localparam int LANE_W     = $clog2(LANES);
  localparam int ROW_W      = CUBE_IDX_W - LANE_W;
  localparam int ROWS       = MAX_CUBES / LANES;

  typedef struct packed {
    logic [IN_W-1:0] care;
    logic [IN_W-1:0] val;
  } cube_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EVAL,
    ST_RESP
  } state_t;
endpackage

// File: rtl/prm_edge_chk_engine_if.sv
// Config, query and result channels of the edge checker.
// master = driver (edge generator / config host), slave = engine.
interface prm_edge_chk_engine_if;
  import prm_chk_pkg::*;

  logic                  cfg_we;
  logic [CUBE_IDX_W-1:0] cfg_addr;
  logic [IN_W-1:0]       cfg_care;
  logic [IN_W-1:0]       cfg_val;
  logic                  cfg_num_we;
  logic [CNT_W-1:0]      cfg_num;
  logic                  cfg_ready;
  logic                  q_valid;
  logic                  q_ready;
  logic [IN_W-1:0]       q_vec;
  logic [ID_W-1:0]       q_id;
  logic                  r_valid;
  logic                  r_ready;
  logic                  r_mask;
  logic [ID_W-1:0]       r_id;
  logic [CUBE_IDX_W-1:0] r_hit_idx;
  logic                  busy;

  modport master (
    output cfg_we, cfg_addr, cfg_care, cfg_val, cfg_num_we, cfg_num,
    output q_valid, q_vec, q_id, r_ready,
    input  cfg_ready, q_ready, r_valid, r_mask, r_id, r_hit_idx, busy
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_care, cfg_val, cfg_num_we, cfg_num,
    input  q_valid, q_vec, q_id, r_ready,
    output cfg_ready, q_ready, r_valid, r_mask, r_id, r_hit_idx, busy
  );
endinterface

// File: rtl/prm_cube_lane.sv
// Combinational single-cube matcher: hit when every cared literal has the required polarity.
module prm_cube_lane
  import prm_chk_pkg::*;
(
  input  logic [IN_W-1:0] vec,
  input  cube_t           cube,
  input  logic            en,
  output logic            hit
);
  assign hit = en && (((vec ^ cube.val) & cube.care) == '0);
endmodule

// File: rtl/prm_edge_chk_engine.sv
// Sequential sum-of-products edge checker: LANES cubes per cycle from a banked table,
// stopping on the first (lowest-index) hit. Result is held until r_ready; config only lands in IDLE.
module prm_edge_chk_engine
  import prm_chk_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  prm_edge_chk_engine_if.slave    bus
);
  state_t                state_q, state_d;
  logic [CUBE_IDX_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]      num_q, num_d;
  logic [IN_W-1:0]       vec_q, vec_d;
  logic [ID_W-1:0]       id_q, id_d;
  logic                  mask_q, mask_d;
  logic [CUBE_IDX_W-1:0] idx_q, idx_d;

  logic                  idle;
  logic                  cfg_we_ok;
  logic [ROW_W-1:0]      rd_row;
  logic [LANES-1:0]      lane_hit;
  logic                  hit_any;
  logic [LANE_W-1:0]     hit_lane;

  assign idle      = (state_q == ST_IDLE);
  assign cfg_we_ok = idle && bus.cfg_we;
  // base is always LANES-aligned, so its upper bits are the row shared by every bank.
  assign rd_row    = base_q[CUBE_IDX_W-1:LANE_W];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    cube_t            bank [ROWS];
    logic [CNT_W-1:0] lane_idx;

    always_ff @(posedge clk) begin
      if (cfg_we_ok && (bus.cfg_addr[LANE_W-1:0] == LANE_W'(l))) begin
        bank[bus.cfg_addr[CUBE_IDX_W-1:LANE_W]] <= '{care: bus.cfg_care, val: bus.cfg_val};
      end
    end

    assign lane_idx = {1'b0, base_q} + CNT_W'(l);

    prm_cube_lane u_lane (
      .vec  (vec_q),
      .cube (bank[rd_row]),
      .en   (lane_idx < num_q),
      .hit  (lane_hit[l])
    );
  end

  always_comb begin
    hit_any  = 1'b0;
    hit_lane = '0;
    for (int l = LANES - 1; l >= 0; l--) begin
      if (lane_hit[l]) begin
        hit_any  = 1'b1;
        hit_lane = LANE_W'(l);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    num_d   = num_q;
    vec_d   = vec_q;
    id_d    = id_q;
    mask_d  = mask_q;
    idx_d   = idx_q;

    if (idle && bus.cfg_num_we) begin
      num_d = (bus.cfg_num > CNT_W'(MAX_CUBES)) ? CNT_W'(MAX_CUBES) : bus.cfg_num;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.q_valid) begin
          vec_d   = bus.q_vec;
          id_d    = bus.q_id;
          base_d  = '0;
          mask_d  = 1'b0;
          idx_d   = '0;
          state_d = (num_q == '0) ? ST_RESP : ST_EVAL;
        end
      end
      ST_EVAL: begin
        if (hit_any) begin
          mask_d  = 1'b1;
          idx_d   = {base_q[CUBE_IDX_W-1:LANE_W], hit_lane};
          state_d = ST_RESP;
        end else if (({1'b0, base_q} + CNT_W'(LANES)) >= num_q) begin
          state_d = ST_RESP;
        end else begin
          base_d = base_q + CUBE_IDX_W'(LANES);
        end
      end
      ST_RESP: begin
        if (bus.r_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      num_q   <= '0;
      vec_q   <= '0;
      id_q    <= '0;
      mask_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      num_q   <= num_d;
      vec_q   <= vec_d;
      id_q    <= id_d;
      mask_q  <= mask_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.q_ready   = idle;
  assign bus.cfg_ready = idle;
  assign bus.busy      = !idle;
  assign bus.r_valid   = (state_q == ST_RESP);
  assign bus.r_mask    = mask_q;
  assign bus.r_id      = id_q;
  assign bus.r_hit_idx = idx_q;
endmodule
